// File: rtl/wisc_mem_pkg.sv
// Shared constants, FSM state type and address helpers for the cache-miss memory arbiter.
package wisc_mem_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = $clog2(LINE_WORDS);
    localparam int ADDR_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } arb_state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & 16'hFFF0;
    endfunction

    // Word offset is ORed into the base so a line never carries into bits [15:4].
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base | {{(ADDR_W-CNT_W-1){1'b0}}, cnt, 1'b0};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Line-word counter: clear wins over enable, wraps naturally, flags the last word.
module fill_counter
    import wisc_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign term = (cnt == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache line fills onto a pipelined main memory; D wins ties, fills run to completion.
module mem_arbiter
    import wisc_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              I_miss_req,
    input  logic [ADDR_W-1:0] I_miss_addr,
    input  logic              D_miss_req,
    input  logic [ADDR_W-1:0] D_miss_addr,
    input  logic              mem_data_valid,
    input  logic [ADDR_W-1:0] mem_data_in,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fill_wen_I,
    output logic              fill_wen_D,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [ADDR_W-1:0] fill_data,
    output logic              I_fill_done,
    output logic              D_fill_done,
    output logic              busy
);

    arb_state_t        state, next_state;
    logic [ADDR_W-1:0] base;
    logic              issuing;
    logic              grant;
    logic              filling;
    logic              issue_en, recv_en, last_word;
    logic [CNT_W-1:0]  issue_cnt, recv_cnt;
    logic              issue_term, recv_term;

    assign filling   = (state != IDLE);
    assign grant     = (state == IDLE) && (D_miss_req || I_miss_req);
    assign issue_en  = filling && issuing;
    assign recv_en   = filling && mem_data_valid;
    assign last_word = recv_en && recv_term;

    fill_counter u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (grant),
        .en   (issue_en),
        .cnt  (issue_cnt),
        .term (issue_term)
    );

    fill_counter u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (grant),
        .en   (recv_en),
        .cnt  (recv_cnt),
        .term (recv_term)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (D_miss_req)
                    next_state = FILL_D;
                else if (I_miss_req)
                    next_state = FILL_I;
            end
            FILL_I, FILL_D: begin
                if (last_word)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Base is latched once at grant; issue runs for exactly one line then stops.
    always_ff @(posedge clk) begin
        if (rst) begin
            base    <= '0;
            issuing <= 1'b0;
        end else begin
            if (grant) begin
                base    <= line_base(D_miss_req ? D_miss_addr : I_miss_addr);
                issuing <= 1'b1;
            end else if (issue_en && issue_term) begin
                issuing <= 1'b0;
            end
        end
    end

    // Outputs are forced low while rst is high, even before the reset edge lands.
    always_comb begin
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_wen_I  = 1'b0;
        fill_wen_D  = 1'b0;
        fill_addr   = '0;
        I_fill_done = 1'b0;
        D_fill_done = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy        = filling;
            mem_en      = issue_en;
            mem_addr    = word_addr(base, issue_cnt);
            fill_addr   = word_addr(base, recv_cnt);
            fill_wen_I  = mem_data_valid && (state == FILL_I);
            fill_wen_D  = mem_data_valid && (state == FILL_D);
            I_fill_done = last_word && (state == FILL_I);
            D_fill_done = last_word && (state == FILL_D);
        end
    end

    assign fill_data = mem_data_in;

endmodule
